// File: rtl/sync_fifo_8x16.sv
// sync_fifo_8x16
//   Single-clock FIFO, DATA_WIDTH x DEPTH (8 x 16 by default), standard
//   (non-fall-through) read timing: dout is registered and presents the word
//   the cycle after an accepted read.
//   Pointers carry one extra wrap bit so full and empty can be told apart when
//   the address bits are equal.
//   Optional feature macro: FIFO_DATA_COUNT_EN adds the data_count output
//   (wr_ptr - rd_ptr, 0..DEPTH).
module sync_fifo_8x16 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
`ifdef FIFO_DATA_COUNT_EN
    output logic [ADDR_WIDTH:0]   data_count,
`endif
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    // Storage array; no reset so it maps onto block RAM / distributed RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_rd_accept;
    logic w_addr_equal;

    // Flags come straight from the registered pointers, so they reflect an
    // occupancy change on the cycle after the operation that caused it.
    assign w_addr_equal = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = w_addr_equal & (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    // A write into a full FIFO and a read from an empty one are dropped; in a
    // simultaneous request this gives read priority when full and write
    // priority when empty without any extra logic.
    assign w_wr_accept = wr_en & ~w_full;
    assign w_rd_accept = rd_en & ~w_empty;

    // Write port of the storage array.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= din;
        end
    end

    // Write pointer: advances on every accepted write, wrap bit toggles on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
        end else if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
    end

    // Read pointer and registered output word; dout only moves on an accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_dout   <= '0;
        end else if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_dout   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    assign dout  = r_dout;
    assign full  = w_full;
    assign empty = w_empty;

`ifdef FIFO_DATA_COUNT_EN
    // Occupancy; modular subtraction of wrap-bit pointers yields 0..DEPTH.
    assign data_count = r_wr_ptr - r_rd_ptr;
`endif

endmodule

// File: tb/tb_sync_fifo_8x16.sv
// Directed self-checking bench for sync_fifo_8x16.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. after the edge has settled and well before the next one.
module tb_sync_fifo_8x16;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       empty;
`ifdef FIFO_DATA_COUNT_EN
    logic [4:0] data_count;
`endif

    int checks;
    int errors;

    sync_fifo_8x16 dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
`ifdef FIFO_DATA_COUNT_EN
        .data_count (data_count),
`endif
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and print the settled state of that transaction.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t wr=%0b rd=%0b din=%02h -> dout=%02h full=%0b empty=%0b",
                 $time, wr_en, rd_en, din, dout, full, empty);
    endtask

    task automatic write_word(input logic [7:0] d);
        din = d; wr_en = 1'b1; rd_en = 1'b0;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        #3;  // before any clock edge
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h want 00", dout); end
`ifdef FIFO_DATA_COUNT_EN
        checks++;
        if (data_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", data_count); end
`endif
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL empty_read_dout: got %02h want 00", dout); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL empty_read_empty: got %0b want 1", empty); end
    endtask

    task automatic test_single();
        write_word(8'hA5);
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_wr: got %0b want 0", empty); end
`ifdef FIFO_DATA_COUNT_EN
        checks++;
        if (data_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", data_count); end
`endif
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'hA5) begin errors++; $display("FAIL single_dout: got %02h want a5", dout); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_rd: got %0b want 1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            checks++;
            if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, full, (i == 15)); end
        end
`ifdef FIFO_DATA_COUNT_EN
        checks++;
        if (data_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", data_count); end
`endif
        write_word(8'hFF);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL overflow_full: got %0b want 1", full); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (dout !== 8'(i)) begin errors++; $display("FAIL fill_read[%0d]: got %02h want %02h", i, dout, 8'(i)); end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained_empty: got %0b want 1", empty); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) write_word(8'(i));
        din = 8'h55; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL full_rw_dout: got %02h want 00", dout); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL full_rw_full: got %0b want 0", full); end
        for (int i = 1; i < 16; i++) begin
            step();
            checks++;
            if (dout !== 8'(i)) begin errors++; $display("FAIL full_rw_drain[%0d]: got %02h want %02h", i, dout, 8'(i)); end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %0b want 1", empty); end
    endtask

    task automatic test_empty_rw();
        // dout still holds 0x0F from the previous drain
        din = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty: got %0b want 0", empty); end
        checks++;
        if (dout !== 8'h0F) begin errors++; $display("FAIL empty_rw_dout_hold: got %02h want 0f", dout); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'h3C) begin errors++; $display("FAIL empty_rw_read: got %02h want 3c", dout); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL empty_rw_final_empty: got %0b want 1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q [$];
        logic [7:0] next_d;
        logic [7:0] exp_d;
        next_d = 8'h10;
        // Preload three words, then 40 simultaneous write/read pairs keep the
        // occupancy at three while the pointers wrap several times.
        for (int i = 0; i < 3; i++) begin
            write_word(next_d);
            exp_q.push_back(next_d);
            next_d++;
        end
        for (int i = 0; i < 40; i++) begin
            din = next_d; wr_en = 1'b1; rd_en = 1'b1;
            exp_q.push_back(next_d);
            next_d++;
            step();
            exp_d = exp_q.pop_front();
            checks++;
            if (dout !== exp_d) begin errors++; $display("FAIL wrap_dout[%0d]: got %02h want %02h", i, dout, exp_d); end
            checks++;
            if (full !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL wrap_flags[%0d]: got full=%0b empty=%0b want 0/0", i, full, empty); end
`ifdef FIFO_DATA_COUNT_EN
            checks++;
            if (data_count !== 5'd3) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 3", i, data_count); end
`endif
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_d = exp_q.pop_front();
            checks++;
            if (dout !== exp_d) begin errors++; $display("FAIL wrap_drain[%0d]: got %02h want %02h", i, dout, exp_d); end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL wrap_final_empty: got %0b want 1", empty); end
    endtask

    task automatic test_reset_midop();
        write_word(8'h11);
        write_word(8'h22);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'h11) begin errors++; $display("FAIL midop_pre_dout: got %02h want 11", dout); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL midop_reset: got empty=%0b dout=%02h want 1/00", empty, dout); end
        @(posedge clk); #1;
        reset = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (dout !== 8'h00 || empty !== 1'b1) begin errors++; $display("FAIL midop_lost: got dout=%02h empty=%0b want 00/1", dout, empty); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
